// File: rtl/regfile_wb_buffer.sv
// Write-back buffer for long-latency register-file writers: round-robin arbitration,
// in-order FIFO, opportunistic drain into the shared write port, and pending-hit queries.
module regfile_wb_buffer #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_src_p         = 2,
  parameter int fifo_els_p        = 4,
  parameter int num_rs_p          = 2,
  parameter int x0_tied_to_zero_p = 1,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_src_p-1:0]                      src_v_i,
  input  logic [num_src_p-1:0][addr_width_lp-1:0]   src_addr_i,
  input  logic [num_src_p-1:0][width_p-1:0]         src_data_i,
  output logic [num_src_p-1:0]                      src_yumi_o,
  input  logic                                      pipe_w_v_i,
  output logic                                      w_v_o,
  output logic [addr_width_lp-1:0]                  w_addr_o,
  output logic [width_p-1:0]                        w_data_o,
  input  logic [num_rs_p-1:0][addr_width_lp-1:0]    r_addr_i,
  output logic [num_rs_p-1:0]                       r_pending_o,
  output logic                                      empty_o,
  output logic                                      full_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam int rr_w_lp  = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  logic [addr_width_lp-1:0] mem_addr_q [fifo_els_p];
  logic [width_p-1:0]       mem_data_q [fifo_els_p];
  logic [ptr_w_lp-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]      count_q, count_d;
  logic [rr_w_lp-1:0]       rr_q, rr_d, win;

  logic [num_src_p-1:0]     is_x0;
  logic [fifo_els_p-1:0]    entry_v;
  logic                     full_raw, grant, enq, deq;

  assign full_raw = (count_q == cnt_w_lp'(fifo_els_p));

  always_comb begin
    for (int s = 0; s < num_src_p; s++) begin
      is_x0[s] = (x0_tied_to_zero_p != 0) && (src_addr_i[s] == '0);
    end
  end

  // Search from rr; while full only x0 discards are eligible, so they are never blocked.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int k = 0; k < num_src_p; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % num_src_p;
      if (!grant && src_v_i[idx] && (!full_raw || is_x0[idx])) begin
        grant = 1'b1;
        win   = rr_w_lp'(idx);
      end
    end
    grant = grant & ~reset_i;
  end

  always_comb begin
    src_yumi_o = '0;
    if (grant) src_yumi_o[win] = 1'b1;
  end

  assign enq   = grant & ~is_x0[win];
  assign deq   = (count_q != '0) & ~pipe_w_v_i & ~reset_i;
  assign w_v_o = deq;
  assign w_addr_o = mem_addr_q[rd_ptr_q];
  assign w_data_o = mem_data_q[rd_ptr_q];
  assign empty_o  = (count_q == '0) | reset_i;
  assign full_o   = full_raw & ~reset_i;

  always_comb begin
    rr_d     = grant ? rr_w_lp'((int'(win) + 1) % num_src_p) : rr_q;
    wr_ptr_d = enq ? wr_ptr_q + ptr_w_lp'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + ptr_w_lp'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq)      count_d = count_q + cnt_w_lp'(1);
    else if (deq && !enq) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_addr_q[wr_ptr_q] <= src_addr_i[win];
      mem_data_q[wr_ptr_q] <= src_data_i[win];
    end
  end

  // A slot is live when its distance from rd_ptr is below count; the draining slot stays live.
  always_comb begin
    entry_v     = '0;
    r_pending_o = '0;
    for (int i = 0; i < fifo_els_p; i++) begin
      logic [ptr_w_lp-1:0] off;
      off        = ptr_w_lp'(i) - rd_ptr_q;
      entry_v[i] = cnt_w_lp'(off) < count_q;
    end
    for (int r = 0; r < num_rs_p; r++) begin
      for (int i = 0; i < fifo_els_p; i++) begin
        if (entry_v[i] && (mem_addr_q[i] == r_addr_i[r]) && !reset_i
            && !((x0_tied_to_zero_p != 0) && (r_addr_i[r] == '0))) begin
          r_pending_o[r] = 1'b1;
        end
      end
    end
  end

endmodule
